// File: rtl/commit_trace_packer_if.sv
// commit_trace_packer_if: 64-bit valid/ready beat stream from the packer to the trace sink.
interface commit_trace_packer_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/commit_trace_packer.sv
// commit_trace_packer: buffers ILA commit records in a FIFO and streams each as three 64-bit beats,
// counting records lost to overflow and flagging the next stored record.
module commit_trace_packer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                coreclk0,
    input  logic                corerst0_n,
    input  logic                trace_en,
    input  logic [1:0]          ila_hartid,
    input  logic [31:0]         ila_csr_time,
    input  logic [39:0]         ila_pc,
    input  logic                ila_instr_valid,
    input  logic [31:0]         ila_instr,
    input  logic                ila_rd_wen,
    input  logic [4:0]          ila_rd_waddr,
    input  logic [63:0]         ila_rd_wdata,
    commit_trace_packer_if.master m,
    input  logic                clear_drops,
    output logic [15:0]         drop_count,
    output logic [ADDR_W:0]     fifo_level
);
    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;
    typedef struct packed {
        logic        drop;
        logic [1:0]  hartid;
        logic        wen;
        logic [4:0]  waddr;
        logic [39:0] pc;
        logic [31:0] instr;
        logic [31:0] ctime;
        logic [63:0] wdata;
    } rec_t;

    rec_t              mem [DEPTH];
    rec_t              head;
    logic [127:0]      hold;
    logic [ADDR_W-1:0] wptr, rptr;
    logic              drop_pending;
    state_t            state, state_n;
    logic              pop;
    logic [63:0]       tdata_n;

    wire push  = trace_en & ila_instr_valid;
    wire full  = fifo_level == (ADDR_W+1)'(DEPTH);
    wire empty = fifo_level == '0;
    wire acc   = push & ~full;
    wire drop  = push & full;
    wire hs    = m.tvalid & m.tready;

    assign head = mem[rptr];

    always_comb begin
        pop     = !empty && (state == IDLE || (state == B2 && hs));
        state_n = pop ? B0 : (state == IDLE || !hs) ? state : state == B0 ? B1 : state == B1 ? B2 : IDLE;
        tdata_n = pop ? {head.hartid, head.wen, head.waddr, head.drop, 15'h0, head.pc}
                : (hs && state == B0) ? hold[127:64]
                : (hs && state == B1) ? hold[63:0] : m.tdata;
    end

    // Storage has no reset; occupancy is tracked by the pointers and level alone.
    always_ff @(posedge coreclk0)
        if (acc)
            mem[wptr] <= {drop_pending, ila_hartid, ila_rd_wen, ila_rd_waddr, ila_pc, ila_instr, ila_csr_time, ila_rd_wdata};

    always_ff @(posedge coreclk0 or negedge corerst0_n)
        if (!corerst0_n) begin
            state        <= IDLE;
            m.tdata      <= '0;
            m.tvalid     <= 1'b0;
            m.tlast      <= 1'b0;
            hold         <= '0;
            wptr         <= '0;
            rptr         <= '0;
            fifo_level   <= '0;
            drop_count   <= '0;
            drop_pending <= 1'b0;
        end else begin
            state        <= state_n;
            m.tdata      <= tdata_n;
            m.tvalid     <= state_n != IDLE;
            m.tlast      <= state_n == B2;
            hold         <= pop ? {head.instr, head.ctime, head.wdata} : hold;
            wptr         <= wptr + ADDR_W'(acc);
            rptr         <= rptr + ADDR_W'(pop);
            fifo_level   <= fifo_level + (ADDR_W+1)'(acc) - (ADDR_W+1)'(pop);
            drop_count   <= clear_drops ? 16'(drop) : (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
            drop_pending <= drop ? 1'b1 : acc ? 1'b0 : drop_pending;
        end
endmodule

// File: tb/tb_commit_trace_packer.sv
// tb_commit_trace_packer: scenario tasks drive commit records; a scoreboard queue of expected
// beats is filled at drive time and drained by a monitor on every stream handshake.
module tb_commit_trace_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en = 1'b1;
    logic [1:0]  ila_hartid = '0;
    logic [31:0] ila_csr_time = '0;
    logic [39:0] ila_pc = '0;
    logic        ila_instr_valid = 1'b0;
    logic [31:0] ila_instr = '0;
    logic        ila_rd_wen = 1'b0;
    logic [4:0]  ila_rd_waddr = '0;
    logic [63:0] ila_rd_wdata = '0;
    logic        clear_drops = 1'b0;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    commit_trace_packer_if tif();

    commit_trace_packer #(.DEPTH(16), .ADDR_W(4)) dut (
        .coreclk0(clk), .corerst0_n(rst_n), .trace_en(trace_en),
        .ila_hartid(ila_hartid), .ila_csr_time(ila_csr_time), .ila_pc(ila_pc),
        .ila_instr_valid(ila_instr_valid), .ila_instr(ila_instr), .ila_rd_wen(ila_rd_wen),
        .ila_rd_waddr(ila_rd_waddr), .ila_rd_wdata(ila_rd_wdata), .m(tif),
        .clear_drops(clear_drops), .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    logic [64:0] exp_q[$];
    logic [64:0] mon_exp;
    int checks = 0;
    int errors = 0;
    int beats = 0;
    bit exp_dp = 1'b0;

    always @(negedge clk)
        if (rst_n && tif.tvalid && tif.tready) begin
            checks++;
            beats++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got=%h last=%b", tif.tdata, tif.tlast);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({tif.tlast, tif.tdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL beat got last=%b data=%h want last=%b data=%h", tif.tlast, tif.tdata, mon_exp[64], mon_exp[63:0]);
                end
            end
        end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic retire_raw(input logic [1:0] h, input logic [39:0] pc, input logic [31:0] ins,
                              input logic [31:0] t, input logic w, input logic [4:0] a,
                              input logic [63:0] d, input bit acc);
        ila_hartid = h; ila_pc = pc; ila_instr = ins; ila_csr_time = t;
        ila_rd_wen = w; ila_rd_waddr = a; ila_rd_wdata = d; ila_instr_valid = 1'b1;
        if (acc) begin
            exp_q.push_back({1'b0, h, w, a, exp_dp, 15'h0, pc});
            exp_q.push_back({1'b0, ins, t});
            exp_q.push_back({1'b1, d});
            exp_dp = 1'b0;
        end else if (trace_en)
            exp_dp = 1'b1;
        @(posedge clk); #1;
        ila_instr_valid = 1'b0;
    endtask

    task automatic retire(input int i, input bit acc);
        retire_raw(i[1:0], 40'h8000_0000 + 40'(i * 4), 32'(32'h13 + i), 32'(i), i[0], i[4:0], {32'hCAFE_0000, 32'(i)}, acc);
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tif.tvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        clear_drops = 1'b1;
        @(posedge clk); #1;
        clear_drops = 1'b0;
    endtask

    task automatic test_reset();
        tif.tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tif.tvalid, tif.tlast, tif.tdata, drop_count, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b l=%b d=%h dc=%h lvl=%0d want all zero", tif.tvalid, tif.tlast, tif.tdata, drop_count, fifo_level);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_trace_en();
        trace_en = 1'b0;
        ila_instr_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        ila_instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd0 || drop_count !== 16'd0 || tif.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL trace_en_off got lvl=%0d dc=%0d v=%b want 0 0 0", fifo_level, drop_count, tif.tvalid);
        end
        trace_en = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        tif.tready = 1'b1;
        retire_raw(2'd2, 40'h8000_0000, 32'h0000_0013, 32'h0000_0100, 1'b1, 5'd5, 64'hDEAD, 1'b1);
        @(negedge clk);
        checks++;
        if (tif.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got tvalid=%b want 0", tif.tvalid);
        end
        @(negedge clk);
        checks++;
        if (tif.tvalid !== 1'b1 || tif.tdata !== 64'hA500_0000_8000_0000 || tif.tlast !== 1'b0) begin
            errors++;
            $display("FAIL single_beat0 got v=%b d=%h l=%b want 1 a500000080000000 0", tif.tvalid, tif.tdata, tif.tlast);
        end
        wait_empty(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain got remaining=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        tif.tready = 1'b0;
        for (int i = 0; i < 4; i++) retire(i, 1'b1);
        @(posedge clk); #1;
        tif.tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!tif.tvalid) break;
            cnt++;
        end
        checks++;
        if (cnt != 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back got valid_cycles=%0d remaining=%0d want 12 0", cnt, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int b0;
        bit prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        b0 = beats;
        tif.tready = 1'b0;
        for (int i = 10; i < 14; i++) retire(i, 1'b1);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            tif.tready = c[0];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (tif.tvalid !== 1'b1 || tif.tdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h want 1 %h", tif.tvalid, tif.tdata, prev_data);
                end
            end
            prev_stall = tif.tvalid & ~tif.tready;
            prev_data = tif.tdata;
            if (exp_q.size() == 0 && !tif.tvalid) break;
        end
        checks++;
        if (beats - b0 != 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_beats got %0d remaining=%0d want 12 0", beats - b0, exp_q.size());
        end
        tif.tready = 1'b1;
    endtask

    task automatic test_burst();
        bit ok;
        pulse_clear();
        tif.tready = 1'b0;
        // The first record sits in the output stage, so 17 are accepted before the FIFO is full.
        for (int i = 0; i < 20; i++) retire(20 + i, i < 17);
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd16 || drop_count !== 16'd3) begin
            errors++;
            $display("FAIL burst_full got lvl=%0d dc=%0d want 16 3", fifo_level, drop_count);
        end
        tif.tready = 1'b1;
        for (int i = 0; i < 3; i++) retire(40 + i, 1'b0);
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd15 || drop_count !== 16'd6) begin
            errors++;
            $display("FAIL full_pop_same_edge got lvl=%0d dc=%0d want 15 6", fifo_level, drop_count);
        end
        wait_empty(150, ok);
        checks++;
        if (!ok || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL burst_drain got remaining=%0d lvl=%0d want 0 0", exp_q.size(), fifo_level);
        end
        retire(60, 1'b1);
        wait_empty(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_flag_record got remaining=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        bit ok;
        pulse_clear();
        tif.tready = 1'b0;
        for (int i = 0; i < 17; i++) retire(80 + i, 1'b1);
        for (int i = 0; i < 65534; i++) retire(0, 1'b0);
        @(negedge clk);
        checks++;
        if (drop_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL drops_fffe got %h want fffe", drop_count);
        end
        for (int i = 0; i < 3; i++) retire(0, 1'b0);
        @(negedge clk);
        checks++;
        if (drop_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL drops_saturate got %h want ffff", drop_count);
        end
        clear_drops = 1'b1;
        retire(0, 1'b0);
        clear_drops = 1'b0;
        @(negedge clk);
        checks++;
        if (drop_count !== 16'd1) begin
            errors++;
            $display("FAIL clear_with_drop got %h want 0001", drop_count);
        end
        tif.tready = 1'b1;
        wait_empty(150, ok);
        checks++;
        if (!ok || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL sat_drain got remaining=%0d lvl=%0d want 0 0", exp_q.size(), fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        tif.tready = 1'b0;
        retire(70, 1'b1);
        retire(71, 1'b1);
        tif.tready = 1'b1;
        @(posedge clk); #1;
        tif.tready = 1'b0;
        @(negedge clk);
        checks++;
        if (tif.tvalid !== 1'b1 || tif.tlast !== 1'b0 || fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL in_beat1 got v=%b l=%b lvl=%0d want 1 0 1", tif.tvalid, tif.tlast, fifo_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tif.tvalid !== 1'b0 || tif.tlast !== 1'b0 || fifo_level !== 5'd0 || tif.tdata !== 64'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b l=%b lvl=%0d d=%h want 0 0 0 0", tif.tvalid, tif.tlast, fifo_level, tif.tdata);
        end
        exp_q.delete();
        exp_dp = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tif.tready = 1'b1;
        retire(72, 1'b1);
        wait_empty(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL post_reset_record got remaining=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_trace_en();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_burst();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
